// File: rtl/assoc_cache_wb.sv
// assoc_cache_wb: 2-way set-associative, write-back, write-allocate cache.
// One outstanding CPU request; misses write back a dirty victim (if needed)
// and then fill the whole line from memory before retrying the lookup.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   cpu_rd, cpu_wr        request strobes, held until cpu_ack (rd wins if both)
//   cpu_addr, cpu_wdata   word address and write data
//   cpu_rdata             read data, held until the next ack
//   cpu_ack               one-cycle completion pulse
//   cpu_stall             high while a miss is being serviced
//   mem_ready             memory can accept a command
//   mem_done              one-cycle completion of a memory command
//   mem_rdata             fill line, word0 in the LSBs
//   mem_addr              block-aligned memory address
//   mem_rd, mem_wr        one-cycle command pulses
//   mem_wdata             write-back line
module assoc_cache_wb #(
  parameter int unsigned WORD_SIZE   = 32,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned SETS        = 4,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cpu_rd,
  input  logic                             cpu_wr,
  input  logic [ADDR_W-1:0]                cpu_addr,
  input  logic [WORD_SIZE-1:0]             cpu_wdata,
  output logic [WORD_SIZE-1:0]             cpu_rdata,
  output logic                             cpu_ack,
  output logic                             cpu_stall,
  input  logic                             mem_ready,
  input  logic                             mem_done,
  input  logic [WORD_SIZE*BLOCK_WORDS-1:0] mem_rdata,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic                             mem_rd,
  output logic                             mem_wr,
  output logic [WORD_SIZE*BLOCK_WORDS-1:0] mem_wdata
);

  localparam int unsigned OFF_W  = $clog2(BLOCK_WORDS);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int unsigned LINE_W = WORD_SIZE * BLOCK_WORDS;

  typedef logic [BLOCK_WORDS-1:0][WORD_SIZE-1:0] line_t;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT
  } state_t;

  // Storage arrays; line data and tags are qualified by valid and need no reset
  line_t              data_mem [2][SETS];
  logic [TAG_W-1:0]   tag_mem  [2][SETS];
  logic [1:0][SETS-1:0] valid_q;
  logic [1:0][SETS-1:0] dirty_q;
  logic [SETS-1:0]    lru_q;
  logic               victim_q;

  // Latched request
  logic [ADDR_W-1:0]    req_addr;
  logic [WORD_SIZE-1:0] req_wdata;
  logic                 req_wr;
  logic [OFF_W-1:0]     req_off;
  logic [IDX_W-1:0]     req_idx;
  logic [TAG_W-1:0]     req_tag;

  assign req_off = req_addr[OFF_W-1:0];
  assign req_idx = req_addr[OFF_W +: IDX_W];
  assign req_tag = req_addr[ADDR_W-1 -: TAG_W];

  state_t               state, state_d;
  logic [WORD_SIZE-1:0] rdata_d;
  logic                 ack_d, stall_d, mem_rd_d, mem_wr_d;
  logic [ADDR_W-1:0]    mem_addr_d;
  logic [LINE_W-1:0]    mem_wdata_d;

  logic accept, hit0, hit1, hit, hit_way, vic_way, vic_dirty;

  // A new request is taken only once the previous ack pulse has dropped
  assign accept = (state == IDLE) && (cpu_rd || cpu_wr) && !cpu_ack;

  // Tag compare; way0 wins if both ways match
  assign hit0    = valid_q[0][req_idx] && (tag_mem[0][req_idx] == req_tag);
  assign hit1    = valid_q[1][req_idx] && (tag_mem[1][req_idx] == req_tag);
  assign hit     = hit0 || hit1;
  assign hit_way = ~hit0;

  // Victim: invalid way first (way0 preferred), else the LRU way
  assign vic_way   = !valid_q[0][req_idx] ? 1'b0 :
                     (!valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx]);
  assign vic_dirty = valid_q[vic_way][req_idx] && dirty_q[vic_way][req_idx];

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
      cpu_stall <= 1'b0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      state     <= state_d;
      cpu_rdata <= rdata_d;
      cpu_ack   <= ack_d;
      cpu_stall <= stall_d;
      mem_addr  <= mem_addr_d;
      mem_rd    <= mem_rd_d;
      mem_wr    <= mem_wr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    rdata_d     = cpu_rdata;
    ack_d       = 1'b0;
    stall_d     = cpu_stall;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    case (state)
      IDLE: begin
        if (accept) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          ack_d   = 1'b1;
          stall_d = 1'b0;
          if (!req_wr) rdata_d = data_mem[hit_way][req_idx][req_off];
          state_d = IDLE;
        end else begin
          stall_d = 1'b1;
          state_d = vic_dirty ? WB_REQ : FILL_REQ;
        end
      end
      WB_REQ: begin
        if (mem_ready) begin
          mem_wr_d    = 1'b1;
          mem_addr_d  = {tag_mem[victim_q][req_idx], req_idx, {OFF_W{1'b0}}};
          mem_wdata_d = data_mem[victim_q][req_idx];
          state_d     = WB_WAIT;
        end
      end
      WB_WAIT: begin
        if (mem_done) state_d = FILL_REQ;
      end
      FILL_REQ: begin
        if (mem_ready) begin
          mem_rd_d   = 1'b1;
          mem_addr_d = {req_tag, req_idx, {OFF_W{1'b0}}};
          state_d    = FILL_WAIT;
        end
      end
      FILL_WAIT: begin
        if (mem_done) state_d = LOOKUP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch plus valid/dirty/LRU/victim bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= '0;
      dirty_q   <= '0;
      lru_q     <= '0;
      victim_q  <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wr    <= 1'b0;
    end else begin
      if (accept) begin
        req_addr  <= cpu_addr;
        req_wdata <= cpu_wdata;
        req_wr    <= cpu_wr && !cpu_rd;
      end
      if (state == LOOKUP) begin
        if (hit) begin
          lru_q[req_idx] <= ~hit_way;
          if (req_wr) dirty_q[hit_way][req_idx] <= 1'b1;
        end else begin
          victim_q <= vic_way;
        end
      end
      if ((state == FILL_WAIT) && mem_done) begin
        valid_q[victim_q][req_idx] <= 1'b1;
        dirty_q[victim_q][req_idx] <= 1'b0;
      end
    end
  end

  // Line data and tag writes
  always_ff @(posedge clk) begin
    if ((state == LOOKUP) && hit && req_wr)
      data_mem[hit_way][req_idx][req_off] <= req_wdata;
    if ((state == FILL_WAIT) && mem_done) begin
      data_mem[victim_q][req_idx] <= mem_rdata;
      tag_mem[victim_q][req_idx]  <= req_tag;
    end
  end

endmodule

// File: tb/tb_assoc_cache_wb.sv
// Directed testbench for assoc_cache_wb with default parameters.
// Backing memory returns (addr - 0x0F) for unwritten words and remembers
// write-backs.
module tb_assoc_cache_wb;
  localparam int unsigned WS = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned ST = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = WS * BW;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_rd, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [WS-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_ack, cpu_stall;
  logic          mem_ready, mem_done;
  logic [LW-1:0] mem_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, mem_wr;

  always #5 clk = ~clk;

  assoc_cache_wb #(.WORD_SIZE(WS), .BLOCK_WORDS(BW), .SETS(ST), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .mem_ready(mem_ready), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata)
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] tbmem [logic [31:0]];

  logic          obs_ack, obs_stall, obs_both, obs_ready_viol;
  logic [WS-1:0] obs_rdata;
  int            obs_ack_cyc, obs_n_rd, obs_n_wr, obs_rd_cyc;
  logic [AW-1:0] obs_rd_addr, obs_wr_addr;
  logic [LW-1:0] obs_wr_data;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (tbmem.exists(a)) return tbmem[a];
    return a - 32'h0F;
  endfunction

  task automatic do_reset();
    reset = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ready = 1'b1; mem_done = 1'b0; mem_rdata = '0;
    tbmem.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // One CPU access with a responding memory; records what was observed.
  // ready_rise != 0 keeps mem_ready low until that cycle; stop_at_rd returns
  // as soon as a fill command is seen, leaving the request pending.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ready_rise, input bit stop_at_rd);
    obs_ack = 0; obs_stall = 1'bx; obs_both = 0; obs_ready_viol = 0; obs_rdata = 'x;
    obs_ack_cyc = 0; obs_n_rd = 0; obs_n_wr = 0; obs_rd_cyc = 0;
    obs_rd_addr = 'x; obs_wr_addr = 'x; obs_wr_data = 'x;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    @(posedge clk); #1;
    mem_ready = (ready_rise == 0);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clk); #1;
      mem_done = 1'b0;
      if (mem_rd && mem_wr) obs_both = 1;
      if (ready_rise != 0 && cyc >= 2 && cyc <= ready_rise && (mem_rd || !cpu_stall))
        obs_ready_viol = 1;
      if (mem_wr) begin
        obs_n_wr++; obs_wr_addr = mem_addr; obs_wr_data = mem_wdata;
        for (int i = 0; i < BW; i++) tbmem[mem_addr + i] = mem_wdata[i*WS +: WS];
        mem_done = 1'b1;
      end
      if (mem_rd) begin
        obs_n_rd++; obs_rd_addr = mem_addr;
        if (obs_rd_cyc == 0) obs_rd_cyc = cyc;
        for (int i = 0; i < BW; i++) mem_rdata[i*WS +: WS] = mem_word(mem_addr + i);
        if (stop_at_rd) return;
        mem_done = 1'b1;
      end
      if (cyc == ready_rise) mem_ready = 1'b1;
      if (cpu_ack) begin
        obs_ack = 1; obs_rdata = cpu_rdata; obs_ack_cyc = cyc; obs_stall = cpu_stall;
        cpu_rd = 1'b0; cpu_wr = 1'b0; mem_ready = 1'b1;
        return;
      end
    end
    cpu_rd = 1'b0; cpu_wr = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if ({cpu_ack, cpu_stall, mem_rd, mem_wr} !== 4'b0) begin n_fail++;
      $display("FAIL reset_ctrl: got ack/stall/rd/wr=%b want 0000", {cpu_ack, cpu_stall, mem_rd, mem_wr}); end
    n_cmp++; if (cpu_rdata !== 32'h0) begin n_fail++;
      $display("FAIL reset_rdata: got %h want 0", cpu_rdata); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_fail++;
      $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== '0) begin n_fail++;
      $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
  endtask

  task automatic test_cold_miss();
    do_reset();
    do_access(1'b1, 1'b0, 32'h12, 32'h0, 0, 1'b0);
    n_cmp++; if (obs_ack !== 1'b1) begin n_fail++; $display("FAIL cold_ack: got %b want 1", obs_ack); end
    n_cmp++; if (obs_n_rd !== 1 || obs_rd_addr !== 32'h10) begin n_fail++;
      $display("FAIL cold_fill: got %0d rd @%h want 1 rd @10", obs_n_rd, obs_rd_addr); end
    n_cmp++; if (obs_rdata !== 32'h3) begin n_fail++; $display("FAIL cold_rdata: got %h want 3", obs_rdata); end
    n_cmp++; if (obs_n_wr !== 0) begin n_fail++; $display("FAIL cold_no_wb: got %0d wr want 0", obs_n_wr); end
    n_cmp++; if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL cold_stall_clear: got %b want 0", obs_stall); end
    do_access(1'b1, 1'b0, 32'h11, 32'h0, 0, 1'b0);
    n_cmp++; if (obs_ack_cyc !== 2) begin n_fail++; $display("FAIL hit_latency: got %0d want 2", obs_ack_cyc); end
    n_cmp++; if (obs_rdata !== 32'h2) begin n_fail++; $display("FAIL hit_rdata: got %h want 2", obs_rdata); end
    n_cmp++; if (obs_n_rd + obs_n_wr !== 0) begin n_fail++;
      $display("FAIL hit_no_mem: got %0d cmds want 0", obs_n_rd + obs_n_wr); end
  endtask

  task automatic test_dirty_evict();
    do_reset();
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 0, 1'b0);
    do_access(1'b0, 1'b1, 32'h13, 32'hAA, 0, 1'b0);
    n_cmp++; if (obs_ack !== 1'b1 || obs_n_rd !== 0) begin n_fail++;
      $display("FAIL wr_hit: got ack=%b rd=%0d want ack=1 rd=0", obs_ack, obs_n_rd); end
    do_access(1'b1, 1'b0, 32'h50, 32'h0, 0, 1'b0);
    n_cmp++; if (obs_n_rd !== 1 || obs_rd_addr !== 32'h50 || obs_n_wr !== 0) begin n_fail++;
      $display("FAIL fill_way1: got rd=%0d @%h wr=%0d want rd=1 @50 wr=0", obs_n_rd, obs_rd_addr, obs_n_wr); end
    do_access(1'b1, 1'b0, 32'h90, 32'h0, 0, 1'b0);
    n_cmp++; if (obs_n_wr !== 1 || obs_wr_addr !== 32'h10) begin n_fail++;
      $display("FAIL wb_addr: got wr=%0d @%h want wr=1 @10", obs_n_wr, obs_wr_addr); end
    n_cmp++; if (obs_wr_data !== {32'hAA, 32'h3, 32'h2, 32'h1}) begin n_fail++;
      $display("FAIL wb_data: got %h want %h", obs_wr_data, {32'hAA, 32'h3, 32'h2, 32'h1}); end
    n_cmp++; if (obs_n_rd !== 1 || obs_rd_addr !== 32'h90 || obs_rdata !== 32'h81) begin n_fail++;
      $display("FAIL evict_fill: got rd=%0d @%h data=%h want rd=1 @90 data=81", obs_n_rd, obs_rd_addr, obs_rdata); end
    n_cmp++; if (obs_both !== 1'b0) begin n_fail++; $display("FAIL rd_wr_overlap: got %b want 0", obs_both); end
    do_access(1'b1, 1'b0, 32'h13, 32'h0, 0, 1'b0);
    n_cmp++; if (obs_n_wr !== 0 || obs_rd_addr !== 32'h10 || obs_rdata !== 32'hAA) begin n_fail++;
      $display("FAIL refetch_wb: got wr=%0d @%h data=%h want wr=0 @10 data=aa", obs_n_wr, obs_rd_addr, obs_rdata); end
  endtask

  task automatic test_write_allocate();
    do_reset();
    do_access(1'b0, 1'b1, 32'h24, 32'h55, 0, 1'b0);
    n_cmp++; if (obs_ack !== 1'b1 || obs_n_rd !== 1 || obs_rd_addr !== 32'h24) begin n_fail++;
      $display("FAIL wa_fill: got ack=%b rd=%0d @%h want ack=1 rd=1 @24", obs_ack, obs_n_rd, obs_rd_addr); end
    do_access(1'b1, 1'b0, 32'h24, 32'h0, 0, 1'b0);
    n_cmp++; if (obs_ack_cyc !== 2 || obs_n_rd !== 0 || obs_rdata !== 32'h55) begin n_fail++;
      $display("FAIL wa_readback: got cyc=%0d rd=%0d data=%h want cyc=2 rd=0 data=55", obs_ack_cyc, obs_n_rd, obs_rdata); end
  endtask

  task automatic test_rd_wr_collision();
    do_reset();
    do_access(1'b1, 1'b1, 32'h30, 32'hDEAD, 0, 1'b0);
    n_cmp++; if (obs_rdata !== 32'h21) begin n_fail++; $display("FAIL rdwr_read: got %h want 21", obs_rdata); end
    do_access(1'b1, 1'b0, 32'h70, 32'h0, 0, 1'b0);
    do_access(1'b1, 1'b0, 32'hB0, 32'h0, 0, 1'b0);
    n_cmp++; if (obs_n_wr !== 0 || obs_rd_addr !== 32'hB0) begin n_fail++;
      $display("FAIL rdwr_clean_evict: got wr=%0d rd@%h want wr=0 rd@b0", obs_n_wr, obs_rd_addr); end
  endtask

  task automatic test_ready_stall();
    do_reset();
    do_access(1'b1, 1'b0, 32'h44, 32'h0, 7, 1'b0);
    n_cmp++; if (obs_ready_viol !== 1'b0) begin n_fail++;
      $display("FAIL ready_hold: got violation=%b want 0", obs_ready_viol); end
    n_cmp++; if (obs_rd_cyc !== 8) begin n_fail++; $display("FAIL ready_rd_cycle: got %0d want 8", obs_rd_cyc); end
    n_cmp++; if (obs_ack !== 1'b1 || obs_rdata !== 32'h35) begin n_fail++;
      $display("FAIL ready_data: got ack=%b data=%h want ack=1 data=35", obs_ack, obs_rdata); end
  endtask

  task automatic test_reset_mid_miss();
    do_reset();
    do_access(1'b1, 1'b0, 32'h18, 32'h0, 0, 1'b1);
    n_cmp++; if (obs_n_rd !== 1) begin n_fail++; $display("FAIL midmiss_reach: got rd=%0d want 1", obs_n_rd); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({mem_rd, cpu_stall, cpu_ack} !== 3'b000) begin n_fail++;
      $display("FAIL midmiss_async: got rd/stall/ack=%b want 000", {mem_rd, cpu_stall, cpu_ack}); end
    cpu_rd = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    do_access(1'b1, 1'b0, 32'h18, 32'h0, 0, 1'b0);
    n_cmp++; if (obs_n_rd !== 1 || obs_rd_addr !== 32'h18 || obs_rdata !== 32'h9) begin n_fail++;
      $display("FAIL midmiss_remiss: got rd=%0d @%h data=%h want rd=1 @18 data=9", obs_n_rd, obs_rd_addr, obs_rdata); end
  endtask

  task automatic test_back_to_back();
    int gap;
    logic [WS-1:0] rd2;
    do_reset();
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 0, 1'b0);
    @(posedge clk); #1;
    cpu_rd = 1'b1; cpu_addr = 32'h11;
    gap = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (cpu_ack) begin gap = c; break; end
    end
    n_cmp++; if (gap !== 2 || cpu_rdata !== 32'h2) begin n_fail++;
      $display("FAIL b2b_first: got cyc=%0d data=%h want cyc=2 data=2", gap, cpu_rdata); end
    cpu_addr = 32'h12;
    gap = 0; rd2 = 'x;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        n_cmp++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL ack_pulse: got %b want 0", cpu_ack); end
      end
      if (cpu_ack) begin gap = c; rd2 = cpu_rdata; break; end
    end
    cpu_rd = 1'b0;
    n_cmp++; if (gap !== 3 || rd2 !== 32'h3) begin n_fail++;
      $display("FAIL b2b_second: got gap=%0d data=%h want gap=3 data=3", gap, rd2); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (cpu_rdata !== 32'h3 || cpu_ack !== 1'b0) begin n_fail++;
      $display("FAIL rdata_hold: got data=%h ack=%b want data=3 ack=0", cpu_rdata, cpu_ack); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_dirty_evict();
    test_write_allocate();
    test_rd_wr_collision();
    test_ready_stall();
    test_reset_mid_miss();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
